tsbus_port: RTL and testbench
=============================

# tsbus_port

Sequential controller for one bidirectional (tristate) data bus shared with an external device, e.g. the SRAM data pins. It serialises single-word write and read requests from the core, owns the drive-enable of the output tristate buffer (`pad_t`, `pad_o`), inserts bus-turnaround gaps whenever bus ownership changes, and captures read data from the input buffer (`pad_i`) after a fixed device latency. It sits between core logic and the pad primitives: OBUFT on the drive side, IBUF on the sample side.

## Interface
- `WIDTH`, 16: data bus width in bits.
- `TURN`, 1: turnaround cycles (≥1) with the bus released, inserted on every change between driven and released.
- `RLAT`, 2: cycles (≥1) from start of a read to the sampling edge of `pad_i`.

- `clock`  in  1  sole clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  request; accepted at a rising edge where `req`=1 and `busy`=0.
- `we`  in  1  1 = write, 0 = read; sampled with `req` at acceptance.
- `wdata`  in  WIDTH  write data; sampled at acceptance.
- `busy`  out  1  high whenever the state is not IDLE; registered decode.
- `rdata`  out  WIDTH  last captured read word; holds its value until the next capture.
- `rvalid`  out  1  one-cycle pulse, coincident with new `rdata`.
- `pad_i`  in  WIDTH  bus value from the input buffer.
- `pad_o`  out  WIDTH  drive value to the OBUFT `I` input.
- `pad_t`  out  1  to the OBUFT `T` input; 1 = high-Z (released), 0 = driven.

## Operation
- States: IDLE, TURN, WRITE, READ. A 1-bit `dir` flag records bus ownership (1 = driven) and always equals `~pad_t`.
- At acceptance, latch `we` and `wdata` into internal registers. `req` while `busy` is ignored; the requester holds `req` until it is accepted.
- IDLE + accepted write:
  - `dir`=1: go to WRITE.
  - `dir`=0: go to TURN, then WRITE.
- IDLE + accepted read:
  - `dir`=0: go to READ.
  - `dir`=1: set `pad_t`<=1 at the accept edge, go to TURN, then READ.
- TURN: `pad_t`=1. Count `TURN` cycles, then enter WRITE or READ according to the latched `we`.
- Entry into WRITE: `pad_o`<=latched data and `pad_t`<=0 on the same edge. WRITE lasts 1 cycle, then IDLE.
- After a write the bus stays parked driven: `pad_t`=0 and `pad_o` holds its value until a read is accepted or reset occurs.
- READ: `pad_t`=1. Count `RLAT` cycles. On the last edge: `rdata`<=`pad_i`, `rvalid`<=1, next state IDLE.
- `rvalid` is 0 in all other cycles.
- Counter: a single down-counter, width $clog2(max(TURN,RLAT))+1, loaded on state entry. The transition occurs when the counter reaches 1.
- `pad_t` never goes 0 in the cycle directly after a released cycle without `TURN` released cycles in between. This includes the first write after reset.

## Timing
- Reset values: state IDLE, `busy`=0, `pad_t`=1, `pad_o`=0, `rdata`=0, `rvalid`=0, `dir`=0, counter 0.
- Reset mid-operation (TURN/WRITE/READ): `pad_t` goes 1 asynchronously. The in-flight request is dropped and no `rvalid` is produced.
- Accept edge = N.
- Write, `dir`=1:
  - `pad_o`/`pad_t`=0 updated at edge N.
  - `busy`=1 in cycle N..N+1.
  - Next accept possible at edge N+2.
- Write, `dir`=0:
  - TURN cycles N..N+TURN.
  - Drive begins at edge N+TURN.
  - IDLE at edge N+TURN+1.
- Read, `dir`=0:
  - Sample at edge N+RLAT; `rvalid` high in the following cycle.
  - IDLE at the same edge.
- Read, `dir`=1:
  - `pad_t`=1 from edge N.
  - Sample at edge N+TURN+RLAT.
- Minimum repeat rate: 2 cycles per write (parked), 1+RLAT cycles per read (released).

## Test plan
- Reset, then idle 5 cycles -> `pad_t`=1, `pad_o`=0x0000, `busy`=0, `rvalid`=0, `rdata`=0x0000. Assert `reset_n` low mid-cycle while driving -> `pad_t`=1 immediately.
- First write 0xA5A5 after reset (TURN=1), accept at N -> `pad_t`=1 in cycle N..N+1. At edge N+1: `pad_t`=0, `pad_o`=0xA5A5. `busy` falls at N+2.
- Second write 0x1234, accepted immediately -> drive changes at the accept edge with no TURN. `pad_t` stays 0 and `pad_o` holds 0x1234 for 10 idle cycles.
- Read while parked driven, `pad_i` driven 0xBEEF (RLAT=2) -> `pad_t`=1 at N. `rdata`=0xBEEF and `rvalid` pulse for exactly 1 cycle after edge N+3. `busy` low after N+3.
- Read then write 0x00FF -> TURN inserted before drive. `pad_t` never 0 earlier than edge accept+1. `req` held high during `busy` is not double-accepted.
- Reset asserted during READ, one cycle before the sample edge -> no `rvalid`, `rdata` = 0x0000. The next read completes normally.

Source files
------------

// File: rtl/tsbus_port_if.sv
// Signal bundle between the core, the tsbus_port controller and the pad buffers.
// Handshake: a request is taken on a rising edge where req=1 and busy=0; the
// requester holds req/we/wdata stable until then. rvalid is a 1-cycle pulse with rdata.
interface tsbus_port_if #(
    parameter int WIDTH = 16
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic [WIDTH-1:0] rdata;
    logic             rvalid;
    logic [WIDTH-1:0] pad_i;
    logic [WIDTH-1:0] pad_o;
    logic             pad_t;

    modport master (
        output req, we, wdata, pad_i,
        input  busy, rdata, rvalid, pad_o, pad_t
    );

    modport slave (
        input  req, we, wdata, pad_i,
        output busy, rdata, rvalid, pad_o, pad_t
    );
endinterface

// File: rtl/tsbus_port.sv
// Single-word read/write sequencer for a shared tristate bus, with turnaround
// gaps on every ownership change and fixed-latency read capture.
module tsbus_port #(
    parameter int WIDTH = 16,
    parameter int TURN  = 1,
    parameter int RLAT  = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    tsbus_port_if.slave  bus,
    output logic [1:0]   state
);
    localparam int MAXC = (TURN > RLAT) ? TURN : RLAT;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TURN  = 2'd1,
        S_WRITE = 2'd2,
        S_READ  = 2'd3
    } state_t;

    state_t           st, st_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             dir;
    logic             we_q;
    logic [WIDTH-1:0] data_q;
    logic             pad_t_q, pad_t_nx;
    logic [WIDTH-1:0] pad_o_q, pad_o_nx;
    logic [WIDTH-1:0] rdata_q, rdata_nx;
    logic             rvalid_q, rvalid_nx;
    logic             busy_q;
    logic             accept;

    assign accept = (st == S_IDLE) && bus.req;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st       <= S_IDLE;
            cnt      <= '0;
            dir      <= 1'b0;
            we_q     <= 1'b0;
            data_q   <= '0;
            pad_t_q  <= 1'b1;
            pad_o_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            st       <= st_nx;
            cnt      <= cnt_nx;
            pad_t_q  <= pad_t_nx;
            pad_o_q  <= pad_o_nx;
            rdata_q  <= rdata_nx;
            rvalid_q <= rvalid_nx;
            dir      <= ~pad_t_nx;
            busy_q   <= (st_nx != S_IDLE);
            if (accept) begin
                we_q   <= bus.we;
                data_q <= bus.wdata;
            end
        end
    end

    // Turnaround is needed whenever the requested direction differs from the current owner.
    always_comb begin
        st_nx  = st;
        cnt_nx = cnt;
        case (st)
            S_IDLE: begin
                if (accept) begin
                    if (bus.we == dir) begin
                        st_nx  = bus.we ? S_WRITE : S_READ;
                        cnt_nx = bus.we ? '0 : CW'(RLAT);
                    end else begin
                        st_nx  = S_TURN;
                        cnt_nx = CW'(TURN);
                    end
                end
            end
            S_TURN: begin
                if (cnt <= CW'(1)) begin
                    st_nx  = we_q ? S_WRITE : S_READ;
                    cnt_nx = we_q ? '0 : CW'(RLAT);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_WRITE: begin
                st_nx  = S_IDLE;
                cnt_nx = '0;
            end
            S_READ: begin
                if (cnt <= CW'(1)) begin
                    st_nx  = S_IDLE;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: begin
                st_nx  = S_IDLE;
                cnt_nx = '0;
            end
        endcase
    end

    // On a parked-driven write the data comes straight from the request, not the latch.
    always_comb begin
        pad_t_nx  = pad_t_q;
        pad_o_nx  = pad_o_q;
        rdata_nx  = rdata_q;
        rvalid_nx = 1'b0;
        if (st_nx == S_WRITE && st != S_WRITE) begin
            pad_o_nx = (st == S_IDLE) ? bus.wdata : data_q;
            pad_t_nx = 1'b0;
        end
        if (st_nx == S_TURN || st_nx == S_READ) begin
            pad_t_nx = 1'b1;
        end
        if (st == S_READ && st_nx == S_IDLE) begin
            rdata_nx  = bus.pad_i;
            rvalid_nx = 1'b1;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.pad_o  = pad_o_q;
    assign bus.pad_t  = pad_t_q;
    assign state      = st;

endmodule

// File: tb/tb_tsbus_port.sv
// Directed bench for tsbus_port: timed checks on pad drive/busy plus a read-data scoreboard.
module tb_tsbus_port;
    localparam int W = 16;

    logic       clock;
    logic       reset_n;
    logic [1:0] state;

    tsbus_port_if #(.WIDTH(W)) bif ();

    tsbus_port #(.WIDTH(W), .TURN(1), .RLAT(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bif.slave),
        .state   (state)
    );

    logic [W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic wr, input logic [W-1:0] d);
        bif.req   = 1'b1;
        bif.we    = wr;
        bif.wdata = d;
    endtask

    // scoreboard monitor
    always @(negedge clock) begin
        if (bif.rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rvalid: rdata 0x%0h with empty queue at %0t", bif.rdata, $time);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("rdata_sb", 32'(bif.rdata), 32'(e));
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        bif.req   = 1'b0;
        bif.we    = 1'b0;
        bif.wdata = '0;
        bif.pad_i = '0;
        repeat (3) tick();
        #2 reset_n = 1'b1;

        // reset state after idling
        repeat (5) tick();
        check("rst_pad_t",  32'(bif.pad_t), 32'd1);
        check("rst_pad_o",  32'(bif.pad_o), 32'h0000);
        check("rst_busy",   32'(bif.busy), 32'd0);
        check("rst_rvalid", 32'(bif.rvalid), 32'd0);
        check("rst_rdata",  32'(bif.rdata), 32'h0000);
        check("rst_state",  32'(state), 32'd0);

        // first write after reset needs a turnaround
        issue(1'b1, 16'hA5A5);
        tick();
        bif.req = 1'b0;
        check("w1_turn_pad_t", 32'(bif.pad_t), 32'd1);
        check("w1_turn_busy",  32'(bif.busy), 32'd1);
        check("w1_turn_state", 32'(state), 32'd1);
        tick();
        check("w1_drive_pad_t", 32'(bif.pad_t), 32'd0);
        check("w1_drive_pad_o", 32'(bif.pad_o), 32'hA5A5);
        check("w1_drive_busy",  32'(bif.busy), 32'd1);
        tick();
        check("w1_done_busy", 32'(bif.busy), 32'd0);

        // parked write: drive changes at the accept edge
        issue(1'b1, 16'h1234);
        tick();
        bif.req = 1'b0;
        check("w2_pad_t",  32'(bif.pad_t), 32'd0);
        check("w2_pad_o",  32'(bif.pad_o), 32'h1234);
        check("w2_busy",   32'(bif.busy), 32'd1);
        check("w2_state",  32'(state), 32'd2);
        tick();
        check("w2_done_busy", 32'(bif.busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("park_pad_t", 32'(bif.pad_t), 32'd0);
            check("park_pad_o", 32'(bif.pad_o), 32'h1234);
        end

        // read while parked driven
        bif.pad_i = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        issue(1'b0, '0);
        tick();
        bif.req = 1'b0;
        check("r1_release_pad_t", 32'(bif.pad_t), 32'd1);
        check("r1_busy",          32'(bif.busy), 32'd1);
        tick();
        check("r1_n1_rvalid", 32'(bif.rvalid), 32'd0);
        tick();
        check("r1_n2_rvalid", 32'(bif.rvalid), 32'd0);
        check("r1_n2_pad_t",  32'(bif.pad_t), 32'd1);
        tick();
        check("r1_n3_rvalid", 32'(bif.rvalid), 32'd1);
        check("r1_n3_rdata",  32'(bif.rdata), 32'hBEEF);
        check("r1_n3_busy",   32'(bif.busy), 32'd0);
        tick();
        check("r1_pulse_end", 32'(bif.rvalid), 32'd0);
        check("r1_rdata_hold", 32'(bif.rdata), 32'hBEEF);

        // read, then a write requested while busy and held
        bif.pad_i = 16'h1111;
        exp_q.push_back(16'h1111);
        issue(1'b0, '0);
        tick();
        check("rw_read_state", 32'(state), 32'd3);
        issue(1'b1, 16'h00FF);
        tick();
        check("rw_n1_state", 32'(state), 32'd3);
        check("rw_n1_pad_t", 32'(bif.pad_t), 32'd1);
        tick();
        check("rw_n2_state",  32'(state), 32'd0);
        check("rw_n2_rvalid", 32'(bif.rvalid), 32'd1);
        check("rw_n2_pad_t",  32'(bif.pad_t), 32'd1);
        tick();
        bif.req = 1'b0;
        check("rw_acc_state", 32'(state), 32'd1);
        check("rw_acc_pad_t", 32'(bif.pad_t), 32'd1);
        tick();
        check("rw_drive_pad_t", 32'(bif.pad_t), 32'd0);
        check("rw_drive_pad_o", 32'(bif.pad_o), 32'h00FF);
        tick();
        check("rw_done_busy", 32'(bif.busy), 32'd0);
        repeat (3) tick();
        check("rw_no_double", 32'(state), 32'd0);
        check("rw_park_pad_o", 32'(bif.pad_o), 32'h00FF);

        // reset one cycle before the read sample edge
        bif.pad_i = 16'hDEAD;
        issue(1'b0, '0);
        tick();
        bif.req = 1'b0;
        check("rr_turn_state", 32'(state), 32'd1);
        tick();
        tick();
        check("rr_read_state", 32'(state), 32'd3);
        reset_n = 1'b0;
        #1;
        check("rr_async_pad_t", 32'(bif.pad_t), 32'd1);
        check("rr_async_rdata", 32'(bif.rdata), 32'h0000);
        check("rr_async_state", 32'(state), 32'd0);
        tick();
        check("rr_no_rvalid", 32'(bif.rvalid), 32'd0);
        #2 reset_n = 1'b1;
        tick();
        bif.pad_i = 16'hCAFE;
        exp_q.push_back(16'hCAFE);
        issue(1'b0, '0);
        tick();
        bif.req = 1'b0;
        check("rr2_state", 32'(state), 32'd3);
        tick();
        tick();
        check("rr2_rvalid", 32'(bif.rvalid), 32'd1);
        check("rr2_rdata",  32'(bif.rdata), 32'hCAFE);
        tick();

        // asynchronous release while parked driven
        issue(1'b1, 16'h5A5A);
        tick();
        bif.req = 1'b0;
        tick();
        tick();
        check("ar_pre_pad_t", 32'(bif.pad_t), 32'd0);
        check("ar_pre_pad_o", 32'(bif.pad_o), 32'h5A5A);
        #2 reset_n = 1'b0;
        #1;
        check("ar_pad_t", 32'(bif.pad_t), 32'd1);
        check("ar_pad_o", 32'(bif.pad_o), 32'h0000);
        check("ar_busy",  32'(bif.busy), 32'd0);
        #2 reset_n = 1'b1;
        repeat (2) tick();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
